// File: rtl/reset_seq_pkg.sv
// Shared types and helpers for the staged reset sequencer.
// State encoding is fixed so the observability port is stable.
package reset_seq_pkg;

    typedef enum logic [2:0] {
        S_ASSERT    = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_HOLD      = 3'd2,
        S_RELEASE   = 3'd3,
        S_RUN       = 3'd4
    } state_e;

    localparam int LOST_CNT_W = 8;

    // Width able to hold the largest of the three cycle counts.
    function automatic int cnt_width(
        input int a,
        input int b,
        input int c
    );
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/reset_sync_n.sv
// SYNC_DEPTH-flop synchronizer, asynchronously forced to RST_VAL.
// RST_VAL=1 with i_d=0 gives an active-high reset; RST_VAL=0 passes data.
module reset_sync_n
    import reset_seq_pkg::*;
#(
    parameter int SYNC_DEPTH = 2,
    parameter bit RST_VAL    = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [SYNC_DEPTH-1:0] r_sync;

    // Shift chain; async force on rst_n, release/data enter at bit 0.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= {SYNC_DEPTH{RST_VAL}};
        end else begin
            r_sync <= {r_sync[SYNC_DEPTH-2:0], i_d};
        end
    end

    assign o_q = r_sync[SYNC_DEPTH-1];

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset release for MAC, FIFO and DMA domains after PLL lock.
// Re-asserts every stage together on lock loss or software request.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int SYNC_DEPTH  = 2,
    parameter int N_OUT       = 3,
    parameter int LOCK_FILTER = 4,
    parameter int HOLD_CYCLES = 16,
    parameter int STAGE_GAP   = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  lock,
    input  logic                  sw_rst,
    output logic [N_OUT-1:0]      rst_out,
    output logic                  ready,
    output logic [2:0]            state,
    output logic [LOST_CNT_W-1:0] lock_lost_cnt
);

    localparam int CW =
        cnt_width(HOLD_CYCLES, STAGE_GAP, LOCK_FILTER);
    localparam int IW = $clog2(N_OUT + 1);

    localparam logic [CW-1:0] FILT_LAST = CW'(LOCK_FILTER - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(STAGE_GAP - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(N_OUT - 1);
    localparam logic [IW-1:0] IDX_ONE   = IW'(1);

    logic w_rst_i;
    logic w_lock_s;

    state_e                r_state;
    state_e                w_nxt_state;
    logic [N_OUT-1:0]      r_rst_out;
    logic [N_OUT-1:0]      w_nxt_rst_out;
    logic                  r_ready;
    logic                  w_nxt_ready;
    logic [LOST_CNT_W-1:0] r_lost;
    logic [LOST_CNT_W-1:0] w_nxt_lost;
    logic [CW-1:0]         r_filt;
    logic [CW-1:0]         w_nxt_filt;
    logic [CW-1:0]         r_cnt;
    logic [CW-1:0]         w_nxt_cnt;
    logic [IW-1:0]         r_idx;
    logic [IW-1:0]         w_nxt_idx;

    logic w_active;
    logic w_abort;
    logic w_loss;

    reset_sync_n #(
        .SYNC_DEPTH (SYNC_DEPTH),
        .RST_VAL    (1'b1)
    ) u_rst_sync (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_d     (1'b0),
        .o_q     (w_rst_i)
    );

    reset_sync_n #(
        .SYNC_DEPTH (SYNC_DEPTH),
        .RST_VAL    (1'b0)
    ) u_lock_sync (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_d     (lock),
        .o_q     (w_lock_s)
    );

    // Abort covers the states where any stage may already be released.
    always_comb begin
        w_active = (r_state == S_HOLD)
                || (r_state == S_RELEASE)
                || (r_state == S_RUN);
        w_loss   = w_active && !w_lock_s;
        w_abort  = w_active && (sw_rst || !w_lock_s);
    end

    // Next-state, counters and registered output values.
    always_comb begin
        w_nxt_state   = r_state;
        w_nxt_rst_out = r_rst_out;
        w_nxt_ready   = r_ready;
        w_nxt_filt    = r_filt;
        w_nxt_cnt     = r_cnt;
        w_nxt_idx     = r_idx;
        w_nxt_lost    = r_lost;

        if (!w_rst_i && w_loss && (r_lost != '1)) begin
            w_nxt_lost = r_lost + 1'b1;
        end

        if (w_rst_i) begin
            w_nxt_state   = S_ASSERT;
            w_nxt_rst_out = '1;
            w_nxt_ready   = 1'b0;
            w_nxt_filt    = '0;
            w_nxt_cnt     = '0;
            w_nxt_idx     = '0;
        end else if (w_abort) begin
            w_nxt_state   = S_WAIT_LOCK;
            w_nxt_rst_out = '1;
            w_nxt_ready   = 1'b0;
            w_nxt_filt    = '0;
            w_nxt_cnt     = '0;
            w_nxt_idx     = '0;
        end else begin
            unique case (r_state)
                S_ASSERT: begin
                    w_nxt_state = S_WAIT_LOCK;
                    w_nxt_filt  = '0;
                end
                S_WAIT_LOCK: begin
                    if (sw_rst || !w_lock_s) begin
                        w_nxt_filt = '0;
                    end else if (r_filt == FILT_LAST) begin
                        w_nxt_state = S_HOLD;
                        w_nxt_filt  = '0;
                        w_nxt_cnt   = '0;
                    end else begin
                        w_nxt_filt = r_filt + 1'b1;
                    end
                end
                S_HOLD: begin
                    if (r_cnt == HOLD_LAST) begin
                        for (int i = 0; i < N_OUT; i++) begin
                            w_nxt_rst_out[i] = (i != 0);
                        end
                        w_nxt_cnt = '0;
                        if (N_OUT == 1) begin
                            w_nxt_state = S_RUN;
                            w_nxt_ready = 1'b1;
                            w_nxt_idx   = '0;
                        end else begin
                            w_nxt_state = S_RELEASE;
                            w_nxt_idx   = IDX_ONE;
                        end
                    end else begin
                        w_nxt_cnt = r_cnt + 1'b1;
                    end
                end
                S_RELEASE: begin
                    if (r_cnt == GAP_LAST) begin
                        for (int i = 0; i < N_OUT; i++) begin
                            w_nxt_rst_out[i] = (IW'(i) > r_idx);
                        end
                        w_nxt_cnt = '0;
                        if (r_idx == IDX_LAST) begin
                            w_nxt_state = S_RUN;
                            w_nxt_ready = 1'b1;
                            w_nxt_idx   = '0;
                        end else begin
                            w_nxt_idx = r_idx + 1'b1;
                        end
                    end else begin
                        w_nxt_cnt = r_cnt + 1'b1;
                    end
                end
                S_RUN: begin
                    w_nxt_state = S_RUN;
                end
                default: begin
                    w_nxt_state   = S_ASSERT;
                    w_nxt_rst_out = '1;
                    w_nxt_ready   = 1'b0;
                end
            endcase
        end
    end

    // State and output registers, all forced on board reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_ASSERT;
            r_rst_out <= '1;
            r_ready   <= 1'b0;
            r_lost    <= '0;
            r_filt    <= '0;
            r_cnt     <= '0;
            r_idx     <= '0;
        end else begin
            r_state   <= w_nxt_state;
            r_rst_out <= w_nxt_rst_out;
            r_ready   <= w_nxt_ready;
            r_lost    <= w_nxt_lost;
            r_filt    <= w_nxt_filt;
            r_cnt     <= w_nxt_cnt;
            r_idx     <= w_nxt_idx;
        end
    end

    assign rst_out       = r_rst_out;
    assign ready         = r_ready;
    assign state         = r_state;
    assign lock_lost_cnt = r_lost;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with default parameters.
// Table rows drive inputs, wait edges, then compare all outputs.
module tb_reset_sequencer;

    localparam logic [2:0] ST_A = 3'd0;
    localparam logic [2:0] ST_W = 3'd1;
    localparam logic [2:0] ST_H = 3'd2;
    localparam logic [2:0] ST_R = 3'd3;
    localparam logic [2:0] ST_U = 3'd4;

    typedef struct {
        logic       lock;
        logic       sw;
        int         n;
        logic [2:0] rst;
        logic       rdy;
        logic [2:0] st;
        logic [7:0] lost;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic       lock;
    logic       sw_rst;
    logic [2:0] rst_out;
    logic       ready;
    logic [2:0] state;
    logic [7:0] lock_lost_cnt;

    int total;
    int bad;
    vec_t tbl[$];

    reset_sequencer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .lock          (lock),
        .sw_rst        (sw_rst),
        .rst_out       (rst_out),
        .ready         (ready),
        .state         (state),
        .lock_lost_cnt (lock_lost_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(
        input string      nm,
        input logic [2:0] r,
        input logic       y,
        input logic [2:0] s,
        input logic [7:0] l
    );
        total++;
        if (rst_out !== r || ready !== y
            || state !== s || lock_lost_cnt !== l) begin
            bad++;
            $display("FAIL %s: got rst=%b rdy=%b st=%0d lost=%0d want rst=%b rdy=%b st=%0d lost=%0d",
                     nm, rst_out, ready, state, lock_lost_cnt,
                     r, y, s, l);
        end
    endtask

    task automatic add(
        input logic       l,
        input logic       s,
        input int         n,
        input logic [2:0] r,
        input logic       y,
        input logic [2:0] st,
        input logic [7:0] lo
    );
        vec_t v;
        v.lock = l;
        v.sw   = s;
        v.n    = n;
        v.rst  = r;
        v.rdy  = y;
        v.st   = st;
        v.lost = lo;
        tbl.push_back(v);
    endtask

    initial begin
        int exp_lost;
        total  = 0;
        bad    = 0;
        rst_n  = 1'b0;
        lock   = 1'b1;
        sw_rst = 1'b0;

        // power-up sequence, lock high throughout
        add(1, 0,  2, 3'b111, 0, ST_A, 0);
        add(1, 0,  1, 3'b111, 0, ST_W, 0);
        add(1, 0,  3, 3'b111, 0, ST_W, 0);
        add(1, 0,  1, 3'b111, 0, ST_H, 0);
        add(1, 0, 15, 3'b111, 0, ST_H, 0);
        add(1, 0,  1, 3'b110, 0, ST_R, 0);
        add(1, 0,  7, 3'b110, 0, ST_R, 0);
        add(1, 0,  1, 3'b100, 0, ST_R, 0);
        add(1, 0,  7, 3'b100, 0, ST_R, 0);
        add(1, 0,  1, 3'b000, 1, ST_U, 0);
        add(1, 0,  5, 3'b000, 1, ST_U, 0);
        // one-cycle lock drop in RUN
        add(0, 0,  1, 3'b000, 1, ST_U, 0);
        add(1, 0,  1, 3'b000, 1, ST_U, 0);
        add(1, 0,  1, 3'b111, 0, ST_W, 1);
        add(1, 0,  3, 3'b111, 0, ST_W, 1);
        add(1, 0,  1, 3'b111, 0, ST_H, 1);
        add(1, 0, 16, 3'b110, 0, ST_R, 1);
        add(1, 0,  8, 3'b100, 0, ST_R, 1);
        add(1, 0,  8, 3'b000, 1, ST_U, 1);
        // software requests in RUN, RELEASE, WAIT_LOCK
        add(1, 1,  1, 3'b111, 0, ST_W, 1);
        add(1, 0,  4, 3'b111, 0, ST_H, 1);
        add(1, 0, 16, 3'b110, 0, ST_R, 1);
        add(1, 0,  3, 3'b110, 0, ST_R, 1);
        add(1, 1,  1, 3'b111, 0, ST_W, 1);
        add(1, 0,  2, 3'b111, 0, ST_W, 1);
        add(1, 1,  1, 3'b111, 0, ST_W, 1);
        add(1, 0,  3, 3'b111, 0, ST_W, 1);
        add(1, 0,  1, 3'b111, 0, ST_H, 1);
        add(1, 0,  5, 3'b111, 0, ST_H, 1);

        step(2);
        chk("reset", 3'b111, 0, ST_A, 0);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            lock   = tbl[i].lock;
            sw_rst = tbl[i].sw;
            step(tbl[i].n);
            chk($sformatf("vec%0d", i), tbl[i].rst,
                tbl[i].rdy, tbl[i].st, tbl[i].lost);
        end
        sw_rst = 1'b0;

        // async reset mid-HOLD, off the clock edge
        #2;
        rst_n = 1'b0;
        lock  = 1'b0;
        #1;
        chk("async_rst", 3'b111, 0, ST_A, 0);
        step(1);
        rst_n = 1'b1;
        step(2);
        chk("rel_hold_a", 3'b111, 0, ST_A, 0);
        step(1);
        chk("rel_leave_a", 3'b111, 0, ST_W, 0);

        // lock glitch restarts the filter
        lock = 1'b1;
        step(3);
        lock = 1'b0;
        step(2);
        lock = 1'b1;
        step(1);
        chk("filt_glitch", 3'b111, 0, ST_W, 0);
        step(4);
        chk("filt_3more", 3'b111, 0, ST_W, 0);
        step(1);
        chk("filt_hold", 3'b111, 0, ST_H, 0);
        step(32);
        chk("run_again", 3'b000, 1, ST_U, 0);

        // repeated lock loss saturates the counter
        for (int i = 0; i < 300; i++) begin
            exp_lost = (i + 1 > 255) ? 255 : i + 1;
            lock = 1'b0;
            step(1);
            lock = 1'b1;
            step(2);
            chk($sformatf("loss%0d", i), 3'b111, 0, ST_W,
                8'(exp_lost));
            step(36);
            chk($sformatf("rerun%0d", i), 3'b000, 1, ST_U,
                8'(exp_lost));
        end
        chk("sat_final", 3'b000, 1, ST_U, 8'd255);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Downstream consumer of a synchronized reset.
- Takes the board-level asynchronous active-low reset plus a PLL/transceiver lock indication.
- Produces N_OUT staged, active-high, synchronous-release resets for the accnet datapath domains: MAC, then FIFOs, then DMA engines.
- Asserts `ready` only after every stage is released, and re-sequences on lock loss or software request.

Parameters:
- SYNC_DEPTH, 2: flops in the reset-release synchronizer and in the lock synchronizer; legal range >=2.
- N_OUT, 3: number of staged reset outputs; legal range >=1.
- LOCK_FILTER, 4: consecutive synchronized-lock-high cycles required before lock counts as stable; legal range >=1.
- HOLD_CYCLES, 16: cycles all outputs stay asserted after lock is stable; legal range >=1.
- STAGE_GAP, 8: cycles between successive stage releases; legal range >=1.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- lock  in  1  asynchronous lock indication from PLL/transceiver.
- sw_rst  in  1  synchronous single-cycle software re-sequence request.
- rst_out  out  N_OUT  active-high resets; bit i released i-th.
- ready  out  1  high when all stages are released.
- state  out  3  current FSM state, for observability.
- lock_lost_cnt  out  8  saturating count of lock-loss events.

Behaviour:
- Reset domain: one clock; reset is asynchronous and active-low (ports clk, rst_n).
- rst_n low, asynchronously: rst_out = all ones, ready = 0, state = ASSERT, lock_lost_cnt = 0, all counters = 0, lock synchronizer = 0.
- rst_n release: passes through a SYNC_DEPTH-flop synchronizer (active-high internal rst_i). FSM is held in ASSERT while rst_i = 1.
- lock: SYNC_DEPTH-flop synchronizer gives lock_s. Filter counter increments while lock_s = 1 in WAIT_LOCK and clears on lock_s = 0. lock_stable = counter reaches LOCK_FILTER.
- ASSERT: first edge with rst_i = 0 -> WAIT_LOCK.
- WAIT_LOCK: on the edge where lock_stable is reached -> HOLD, hold counter = 0. rst_out stays all ones.
- HOLD: counts HOLD_CYCLES edges. On the HOLD_CYCLES-th edge after HOLD entry: rst_out[0] <= 0, stage index = 1, gap counter = 0, state -> RELEASE. If N_OUT = 1, state -> RUN directly and ready <= 1 on that same edge.
- RELEASE: every STAGE_GAP edges, clear rst_out[stage index] and increment the index. On the edge that clears rst_out[N_OUT-1]: ready <= 1, state -> RUN.
- RUN: steady state; outputs held.
- Abort, in WAIT_LOCK/HOLD/RELEASE/RUN, when sw_rst = 1 or (lock_s = 0 and state != WAIT_LOCK):
  - next edge: rst_out = all ones, ready = 0, all counters cleared, state -> WAIT_LOCK.
  - lock_s = 0 in HOLD/RELEASE/RUN increments lock_lost_cnt by 1 (saturates at 255), once per abort edge, even if sw_rst is also high.
  - sw_rst in WAIT_LOCK only clears the filter counter.
  - sw_rst in ASSERT is ignored.
- Ordering invariant: at every edge, rst_out[i] = 0 implies rst_out[j] = 0 for all j < i. Release is monotonic from bit 0 upward; re-assertion is simultaneous for all bits.
- All outputs are registered; no combinational path from input to output.
- Counter widths: $clog2(max(HOLD_CYCLES, STAGE_GAP, LOCK_FILTER) + 1) bits.

Decomposition:
- Package reset_seq_pkg:
  - state enum, 3-bit encoding: ASSERT=0, WAIT_LOCK=1, HOLD=2, RELEASE=3, RUN=4.
  - LOST_CNT_W = 8.
  - counter-width helper function.
- Sub-module reset_sync_n:
  - SYNC_DEPTH flops, async-asserted from rst_n, synchronous release.
  - Output is active-high.
  - A plain (non-reset-asserting) variant is instantiated for lock.

Test Plan:
1. Defaults, lock = 1 throughout, rst_n released -> state goes ASSERT->WAIT_LOCK->HOLD. rst_out[0] falls exactly 16 edges after HOLD entry, rst_out[1] 8 edges later, rst_out[2] and ready 8 edges after that (32 edges after HOLD entry).
2. lock pulses low for 2 cycles during WAIT_LOCK (after 3 high cycles) -> filter restarts; HOLD is entered only after 4 further consecutive lock_s-high cycles.
3. In RUN, lock drops for 1 cycle -> next edge after lock_s falls: rst_out = 3'b111, ready = 0, state = WAIT_LOCK, lock_lost_cnt = 1. Full sequence repeats when lock returns.
4. sw_rst pulse mid-RELEASE (rst_out = 3'b110) -> next edge: rst_out = 3'b111, state = WAIT_LOCK, lock_lost_cnt unchanged.
5. rst_n asserted mid-HOLD, not clock-aligned -> rst_out = 3'b111, ready = 0, state = ASSERT immediately (before the next edge). After release, FSM leaves ASSERT only after SYNC_DEPTH edges.
6. 300 lock-loss events in RUN -> lock_lost_cnt saturates at 255 and does not wrap.
